ann_mem_loader: RTL and testbench
=================================

# ann_mem_loader

Byte-stream loader that fills the ANN unified weight/activation memory before inference. Accepts framed bytes over a valid/ready stream, parses a header holding base address and payload length, and issues one registered write per payload byte on the memory write port (`wr_en`/`wr_addr`/`data_in` of the unified memory). Sits directly upstream of the unified memory. Reports completion, frame count and error status to the top-level controller.

## Interface
- `ADDR_WIDTH`, 14, memory address width; must match the unified memory.
- `SYNC_BYTE`, 8'hA5, frame start marker.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `mem_wr_en` out 1: write strobe to the unified memory.
- `mem_wr_addr` out `ADDR_WIDTH`: write address.
- `mem_wr_data` out 8: write data.
- `busy` out 1: a frame is in progress, from sync accepted through `done`.
- `done` out 1: one-cycle pulse at end of frame.
- `err` out 1: sticky frame error flag.
- `frame_cnt` out 8: number of completed frames, wraps 255 -> 0.

## Operation
- A byte is accepted in any cycle where `s_valid && s_ready`.
- `s_ready` is 1 in every state except DONE and while `rst` is asserted.
- Frame layout: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes, then CSUM if the checksum option is compiled in.
- The start address is `{ADDR_HI,ADDR_LO}[ADDR_WIDTH-1:0]`; upper bits are ignored. LEN is 16-bit unsigned.
- FSM states: IDLE -> HDR_AH -> HDR_AL -> HDR_LH -> HDR_LL -> DATA -> (CSUM) -> DONE -> IDLE.
  - IDLE: non-SYNC bytes are accepted and discarded. An accepted SYNC byte clears `err` and the wrap/checksum trackers, then goes to HDR_AH.
  - HDR_*: each accepted byte latches its field and advances one state.
  - HDR_LL: if LEN==0, go to CSUM when compiled in, else DONE. Otherwise go to DATA.
  - DATA: each accepted byte writes to the current address, then address += 1 modulo 2^ADDR_WIDTH and remaining -= 1. The last byte goes to CSUM or DONE.
  - DONE: `done`=1 for exactly one cycle, `frame_cnt` += 1, `err` updated, then IDLE.
- Address wrap: if the address rolls from 2^ADDR_WIDTH-1 to 0 with payload bytes still remaining, the write continues at address 0 and `err` is set at DONE.
- `err` is otherwise held until the next accepted SYNC byte.
- No new frame can start until DONE completes.
- Reset mid-frame: the frame is abandoned and all outputs go to 0 immediately. A byte accepted in the cycle before reset does not produce a write.
- Reset values: `s_ready`=0 during reset and 1 after; `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `err`=0, `frame_cnt`=0; state=IDLE.

## Timing
- Write latency is 1: a payload byte accepted at edge N drives `mem_wr_en`=1 with its addr/data in cycle N+1. `mem_wr_en` is 0 in all other cycles.
- Throughput is one payload byte per cycle with `s_valid` held high. Back-to-back writes go to consecutive addresses.
- Frame end (last payload byte or CSUM byte accepted at edge N): state DONE in cycle N+1, so `done`=1, `busy` still 1, `s_ready`=0, and the last `mem_wr_en` coincides with `done`. In cycle N+2, `busy`=0 and `s_ready`=1.
- `err` and `frame_cnt` take their new values at the same time as `done`.
- The minimum frame is SYNC plus 4 header bytes with LEN=0: 5 accepted bytes, then one DONE cycle.
- `s_valid` gaps stall the FSM with no state change and no writes.

## Configuration
- `ANN_LOADER_CHECKSUM_EN` defined: CSUM state present after the payload. Checksum holds if the 8-bit sum of all payload bytes plus the CSUM byte equals 0 mod 256. On mismatch, `err` is set at DONE. Payload writes are still performed.
- Not defined: no CSUM state. `err` reflects address wrap only, and the frame ends after the last payload byte.

## Test plan
- Reset then frame A5 00 10 00 04 11 22 33 44 (+CSUM 0x56 if enabled) -> writes 0x11..0x44 at addrs 0x0010..0x0013 on 4 consecutive cycles; `done` pulses once; `err`=0; `frame_cnt`=1.
- Garbage 00 FF 5A, then a valid frame -> garbage is discarded with no writes; the frame loads normally.
- Frame with addr 0x3FFE, LEN=3, data AA BB CC -> writes at 0x3FFE, 0x3FFF, 0x0000; `err`=1 at `done`; `err` is cleared when the next SYNC is accepted.
- LEN=0 frame -> no `mem_wr_en`; `done` 1 cycle after LEN_LO (or CSUM) is accepted; `frame_cnt` increments.
- `s_valid` toggling 1-0-1 during payload -> writes occur only for accepted bytes, at contiguous addresses; `s_ready`=0 only in the DONE cycle.
- `rst` pulse after the 2nd of 4 payload bytes -> outputs clear asynchronously, no further writes, FSM in IDLE; the following full frame loads correctly. With `ANN_LOADER_CHECKSUM_EN`, a wrong CSUM sets `err`=1.

Source files
------------

// File: rtl/ann_mem_loader.sv
// ann_mem_loader: parses SYNC/address/length framed bytes and writes the payload into the unified memory.
// Define ANN_LOADER_CHECKSUM_EN to expect a trailing checksum byte per frame.
`timescale 1ns/1ps
module ann_mem_loader #(
  parameter int         ADDR_WIDTH = 14,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, HDR_AH, HDR_AL, HDR_LH, HDR_LL, DATA, CSUM, DONE
  } state_t;

  state_t                state;
  logic [7:0]            addr_hi;
  logic [7:0]            len_hi;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           remaining;
  logic                  wrap_q;
  logic                  accept;

`ifdef ANN_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  function automatic logic csum_bad(input logic [7:0] sum, input logic [7:0] csum);
    return (sum + csum) != 8'h00;
  endfunction
`endif

  // The loader stalls input only while it presents the end-of-frame pulse.
  assign s_ready = (state != DONE) && !rst;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_hi     <= '0;
      len_hi      <= '0;
      addr_q      <= '0;
      remaining   <= '0;
      wrap_q      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      frame_cnt   <= '0;
`ifdef ANN_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (accept && s_data == SYNC_BYTE) begin
          err    <= 1'b0;
          wrap_q <= 1'b0;
          busy   <= 1'b1;
`ifdef ANN_LOADER_CHECKSUM_EN
          sum_q  <= '0;
`endif
          state  <= HDR_AH;
        end
        HDR_AH: if (accept) begin
          addr_hi <= s_data;
          state   <= HDR_AL;
        end
        HDR_AL: if (accept) begin
          addr_q <= ADDR_WIDTH'({addr_hi, s_data});
          state  <= HDR_LH;
        end
        HDR_LH: if (accept) begin
          len_hi <= s_data;
          state  <= HDR_LL;
        end
        HDR_LL: if (accept) begin
          remaining <= {len_hi, s_data};
          if ({len_hi, s_data} == 16'd0) begin
`ifdef ANN_LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state     <= DONE;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            err       <= wrap_q;
`endif
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= addr_q;
          mem_wr_data <= s_data;
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          remaining   <= remaining - 16'd1;
`ifdef ANN_LOADER_CHECKSUM_EN
          sum_q       <= sum_q + s_data;
`endif
          // Rolling past the top of memory with bytes still to come is a frame error.
          if (addr_q == '1 && remaining > 16'd1) wrap_q <= 1'b1;
          if (remaining == 16'd1) begin
`ifdef ANN_LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state     <= DONE;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            err       <= wrap_q;
`endif
          end
        end
`ifdef ANN_LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          state     <= DONE;
          done      <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          err       <= wrap_q | csum_bad(sum_q, s_data);
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_mem_loader.sv
// Bench for ann_mem_loader: frame-level model predicts writes, done pulses, err and frame_cnt.
`timescale 1ns/1ps
module tb_ann_mem_loader;
  localparam int AW = 14;
`ifdef ANN_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    frame_cnt;

  ann_mem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [AW+7:0] exp_q[$];       // {addr, data} of writes due next cycle
  logic [8:0]    exp_done_q[$];  // {err, frame_cnt} due with the done pulse
  bit            exp_busy = 1'b0;
  logic          exp_err_h = 1'b0;
  logic [7:0]    exp_cnt_h = 8'd0;
  logic [7:0]    model_cnt = 8'd0;
  int            wr_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = '0;

  logic [AW+7:0] cw;
  logic [8:0]    cd;
  bit            cdn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) begin
        cw = exp_q.pop_front();
        chk("wr_en", mem_wr_en, 1);
        chk("wr_addr", mem_wr_addr, cw[AW+7:8]);
        chk("wr_data", mem_wr_data, cw[7:0]);
      end else begin
        chk("wr_en_idle", mem_wr_en, 0);
      end
      if (mem_wr_en) begin
        wr_count++;
        last_addr = mem_wr_addr;
        last_data = mem_wr_data;
      end
      cdn = exp_done_q.size() > 0;
      if (cdn) begin
        cd = exp_done_q.pop_front();
        exp_err_h = cd[8];
        exp_cnt_h = cd[7:0];
      end
      chk("done", done, cdn);
      chk("s_ready", s_ready, !cdn);
      chk("busy", busy, exp_busy);
      chk("err", err, exp_err_h);
      chk("frame_cnt", frame_cnt, exp_cnt_h);
      if (cdn) exp_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_sync, input bit is_pl,
                           input logic [AW-1:0] a, input bit is_last, input logic [8:0] fin);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      $display("FAIL s_ready_timeout: got 0, expected 1 within 8 cycles");
      $fatal(1, "stalled");
    end
    @(posedge clk);
    if (is_sync) begin
      exp_busy  = 1'b1;
      exp_err_h = 1'b0;
    end
    if (is_pl) exp_q.push_back({a, b});
    if (is_last) exp_done_q.push_back(fin);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic settle();
    idle(3);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] addr, input logic [7:0] pl[$],
                            input logic [7:0] csum_delta, input bit gap);
    logic [AW-1:0] a;
    logic [15:0]   len;
    logic [7:0]    sum;
    bit            e;
    logic [8:0]    fin;
    a   = addr[AW-1:0];
    len = 16'(pl.size());
    sum = 8'd0;
    foreach (pl[i]) sum = sum + pl[i];
    e = (int'(a) + int'(len)) > (1 << AW);
    e = e || (CS && csum_delta != 8'd0);
    model_cnt = model_cnt + 8'd1;
    fin = {e, model_cnt};
    send_byte(8'hA5, 1, 0, '0, 0, fin);
    send_byte(addr[15:8], 0, 0, '0, 0, fin);
    send_byte(addr[7:0], 0, 0, '0, 0, fin);
    send_byte(len[15:8], 0, 0, '0, 0, fin);
    send_byte(len[7:0], 0, 0, '0, (len == 16'd0) && !CS, fin);
    for (int i = 0; i < int'(len); i++) begin
      if (gap && i > 0) idle(1);
      send_byte(pl[i], 0, 1, a + AW'(i), (i == int'(len) - 1) && !CS, fin);
    end
    if (CS) send_byte(8'(8'd0 - sum) + csum_delta, 0, 0, '0, 1, fin);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_s_ready", s_ready, 1);

    // Basic frame.
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'h0010, q, 8'd0, 0);
    settle();
    chk("t1_wr_count", wr_count, 4);
    chk("t1_last_addr", last_addr, 14'h0013);
    chk("t1_last_data", last_data, 8'h44);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_err", err, 0);

    // Garbage before a frame; payload contains a SYNC value.
    send_byte(8'h00, 0, 0, '0, 0, 9'd0);
    send_byte(8'hFF, 0, 0, '0, 0, 9'd0);
    send_byte(8'h5A, 0, 0, '0, 0, 9'd0);
    idle(2);
    q = '{8'h5A, 8'hA5};
    send_frame(16'h0100, q, 8'd0, 0);
    settle();
    chk("t2_wr_count", wr_count, 6);
    chk("t2_last_addr", last_addr, 14'h0101);
    chk("t2_last_data", last_data, 8'hA5);
    chk("t2_frame_cnt", frame_cnt, 2);

    // Address wrap.
    q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(16'h3FFE, q, 8'd0, 0);
    settle();
    chk("t3_wr_count", wr_count, 9);
    chk("t3_last_addr", last_addr, 14'h0000);
    chk("t3_last_data", last_data, 8'hCC);
    chk("t3_err", err, 1);
    chk("t3_frame_cnt", frame_cnt, 3);

    // Zero-length frame; its SYNC clears the wrap error.
    q.delete();
    send_frame(16'h0005, q, 8'd0, 0);
    settle();
    chk("t4_err", err, 0);
    chk("t4_wr_count", wr_count, 9);
    chk("t4_frame_cnt", frame_cnt, 4);

    // Valid gaps in payload; upper address bits ignored.
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(16'hC020, q, 8'd0, 1);
    settle();
    chk("t5_wr_count", wr_count, 13);
    chk("t5_last_addr", last_addr, 14'h0023);
    chk("t5_last_data", last_data, 8'h04);
    chk("t5_frame_cnt", frame_cnt, 5);

    // Reset after the 2nd of 4 payload bytes.
    send_byte(8'hA5, 1, 0, '0, 0, 9'd0);
    send_byte(8'h00, 0, 0, '0, 0, 9'd0);
    send_byte(8'h30, 0, 0, '0, 0, 9'd0);
    send_byte(8'h00, 0, 0, '0, 0, 9'd0);
    send_byte(8'h04, 0, 0, '0, 0, 9'd0);
    send_byte(8'h31, 0, 1, 14'h0030, 0, 9'd0);
    send_byte(8'h32, 0, 1, 14'h0031, 0, 9'd0);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    exp_busy = 1'b0;
    exp_err_h = 1'b0;
    exp_cnt_h = 8'd0;
    model_cnt = 8'd0;
    #1;
    chk("t6_wr_en", mem_wr_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_done", done, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(2);
    #1;
    chk("t6_wr_count", wr_count, 14);
    chk("t6_busy_after", busy, 0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'h0010, q, 8'd0, 0);
    settle();
    chk("t6b_wr_count", wr_count, 18);
    chk("t6b_last_addr", last_addr, 14'h0013);
    chk("t6b_frame_cnt", frame_cnt, 1);
    chk("t6b_err", err, 0);

`ifdef ANN_LOADER_CHECKSUM_EN
    // Corrupted checksum byte.
    q = '{8'h01, 8'h02};
    send_frame(16'h0200, q, 8'd1, 0);
    settle();
    chk("t7_err", err, 1);
    chk("t7_frame_cnt", frame_cnt, 2);
    chk("t7_wr_count", wr_count, 20);
`endif

    chk("end_writes_drained", exp_q.size(), 0);
    chk("end_done_drained", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
